id_hazard_ctrl: RTL and testbench
=================================

// Module: id_hazard_ctrl
// PURPOSE
//  Stall/bubble sequencer for the 5-stage pipelined CPU (IF-ID-EXE-MEM-WB), which has no forwarding.
//  Tracks in-flight register writes in a scoreboard and detects RAW hazards on the instruction held in ID.
//  Inserts fixed branch-penalty stalls.
//  Drives cu_wpcir (hold PC and the IF/ID register) and id_bubble (turn the ID->EXE transfer into a NOP).
//  Keeps a saturating count of stall cycles for debug.
// PARAMETERS
//  PIPE_DEPTH  3   in-flight stages whose write is not yet visible to an ID read (EXE, MEM, WB)
//  BR_PENALTY  1   stall cycles after a branch issues from ID (1..15)
//  CNT_W       16  width of the stall-cycle counter
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      asynchronous, active-low reset (rst==0 resets)
//  id_valid    in   1      ID holds a real instruction (0 = NOP/bubble)
//  id_rs       in   5      source register A of the ID instruction
//  id_rt       in   5      source register B of the ID instruction
//  id_use_rs   in   1      ID instruction reads rs
//  id_use_rt   in   1      ID instruction reads rt
//  id_wreg     in   1      ID instruction writes a register
//  id_dest     in   5      destination register of the ID instruction (rd or rt, already muxed)
//  id_branch   in   1      ID instruction is a branch/jump
//  stat_clr    in   1      synchronous clear of stall_cnt
//  cu_wpcir    out  1      1 = hold PC and IF/ID this cycle
//  id_bubble   out  1      1 = load a NOP into ID/EXE this cycle
//  hz_data     out  1      stall cause: RAW data hazard
//  hz_ctrl     out  1      stall cause: branch penalty
//  stall_cnt   out  CNT_W  number of stalled cycles, saturating
// BEHAVIOUR
//  Reset: scoreboard entries all invalid; FSM in IDLE; penalty counter 0; stall_cnt 0.
//   All outputs read 0 while rst==0.
//  Scoreboard: PIPE_DEPTH entries {v, dest}; entry 0 is EXE, last entry is WB.
//   Every cycle, entry[i] <= entry[i-1].
//   entry[0] <= issue ? {id_wreg && id_dest!=0, id_dest} : {0, 0}.
//   issue = id_valid && !cu_wpcir.
//  hz_data (combinational): id_valid && state==IDLE, and a valid entry has dest equal to either
//   - id_rs, with id_use_rs && id_rs!=0, or
//   - id_rt, with id_use_rt && id_rt!=0.
//  Register 0 never causes a hazard, either as source or as destination.
//  FSM states:
//   IDLE: hz_ctrl = 0.
//     If id_valid && id_branch && !hz_data, the branch issues this cycle:
//     go to BR_WAIT and load the penalty counter with BR_PENALTY.
//     A branch that has a data hazard waits in IDLE until the hazard clears.
//   BR_WAIT: hz_ctrl = 1.
//     Decrement the penalty counter each cycle; go to IDLE in the cycle after it reaches 1.
//     hz_data is forced to 0 in this state; the scoreboard keeps shifting in bubbles.
//  Outputs:
//   cu_wpcir  = hz_data | hz_ctrl
//   id_bubble = cu_wpcir
//   Both are combinational, with zero-cycle latency from the ID inputs.
//  A RAW hazard against an instruction k stages ahead (k = 1..PIPE_DEPTH) stalls for
//   PIPE_DEPTH-k+1 cycles.
//  stall_cnt: increments by 1 each cycle that cu_wpcir==1; holds at all-ones when saturated.
//   stat_clr wins over a simultaneous increment; the cycle after clearing reads 0.
//  Reset mid-operation (including during BR_WAIT) discards all pending state immediately.
//   No stall is asserted after release until a new hazard occurs.
// TESTING
//  1. Issue "add r3 <- ..", then "sub .. <- r3, r5" directly behind it
//     -> cu_wpcir=1 for exactly 3 cycles, then the sub issues; stall_cnt=3.
//  2. Same pair with one independent instruction between them
//     -> 2 stall cycles; with two independent instructions -> 1; with three -> 0.
//  3. Writer with id_dest=0 followed by a reader of r0; also id_use_rt=0 on a matching rt
//     -> no stall; stall_cnt remains 0.
//  4. Branch with no hazard, BR_PENALTY=1
//     -> hz_ctrl=1 for 1 cycle, then IDLE.
//     Branch reading r7 right after a write to r7
//     -> 3 hz_data cycles, then 1 hz_ctrl cycle; stall_cnt=4.
//  5. stall_cnt preset near all-ones via stalls (CNT_W=4): stays at 15 under further stalls.
//     stat_clr during a stall -> next cycle reads 0.
//  6. Assert rst=0 in BR_WAIT with a valid scoreboard
//     -> outputs 0 immediately.
//     After release, an independent instruction issues with no stall.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// Purpose : ID-stage stall/bubble sequencer for a 5-stage pipeline that has no forwarding.
// Latency : zero cycles from the ID inputs to cu_wpcir/id_bubble.
// Backpr. : cu_wpcir holds PC and IF/ID, and id_bubble sends a NOP into EXE, while a RAW or branch hazard is active.
//
// Ports:
//   clk, rst           rising-edge clock; asynchronous active-low reset
//   id_*               decoded fields of the instruction currently held in ID
//   stat_clr           synchronous clear of stall_cnt
//   cu_wpcir/id_bubble stall request (hold front end / inject bubble)
//   hz_data/hz_ctrl    stall cause: RAW data hazard / branch penalty
//   stall_cnt          saturating count of stalled cycles
module id_hazard_ctrl #(
  parameter int PIPE_DEPTH = 3,
  parameter int BR_PENALTY = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic [4:0]       id_dest,
  input  logic             id_branch,
  input  logic             stat_clr,
  output logic             cu_wpcir,
  output logic             id_bubble,
  output logic             hz_data,
  output logic             hz_ctrl,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, BR_WAIT} state_t;

  state_t                state;
  logic [3:0]            pen_cnt;
  logic                  hz_ctrl_q;
  logic [PIPE_DEPTH-1:0] sb_v;
  logic [4:0]            sb_dest [PIPE_DEPTH];
  logic                  raw_hit;
  logic                  issue;

  // Compare the ID sources against every in-flight write.
  // Register 0 can never match, because sb_v is cleared for dest==0.
  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (sb_v[i] &&
          ((id_use_rs && (id_rs != 5'd0) && (id_rs == sb_dest[i])) ||
           (id_use_rt && (id_rt != 5'd0) && (id_rt == sb_dest[i])))) begin
        raw_hit = 1'b1;
      end
    end
  end

  // A data hazard is masked during branch penalty cycles.
  assign hz_data   = id_valid && (state == IDLE) && raw_hit;
  assign hz_ctrl   = hz_ctrl_q;
  assign cu_wpcir  = hz_data | hz_ctrl;
  assign id_bubble = cu_wpcir;
  assign issue     = id_valid && !cu_wpcir;

  // Scoreboard: entry 0 is EXE and the last entry is WB.
  // A stalled or invalid ID slot shifts in an empty entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_v <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) sb_dest[i] <= 5'd0;
    end else begin
      sb_v[0]    <= issue && id_wreg && (id_dest != 5'd0);
      sb_dest[0] <= issue ? id_dest : 5'd0;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        sb_v[i]    <= sb_v[i-1];
        sb_dest[i] <= sb_dest[i-1];
      end
    end
  end

  // Branch-penalty FSM. The FSM stays in BR_WAIT for exactly BR_PENALTY cycles.
  // A branch that still has a RAW hazard does not issue, so it waits in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pen_cnt   <= 4'd0;
      hz_ctrl_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (id_valid && id_branch && !hz_data) begin
            state     <= BR_WAIT;
            pen_cnt   <= 4'(BR_PENALTY);
            hz_ctrl_q <= 1'b1;
          end
        end
        BR_WAIT: begin
          if (pen_cnt <= 4'd1) begin
            state     <= IDLE;
            pen_cnt   <= 4'd0;
            hz_ctrl_q <= 1'b0;
          end else begin
            pen_cnt <= pen_cnt - 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          pen_cnt   <= 4'd0;
          hz_ctrl_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating stall counter. A clear takes priority over an increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
    end else if (cu_wpcir && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Purpose : random and directed stimulus for id_hazard_ctrl, checked against a behavioural model.
// Latency : outputs are sampled on the falling edge; the model state advances on the rising edge.
// Backpr. : the bench holds the ID instruction while the model predicts a stall.
module tb_id_hazard_ctrl;

  localparam int PIPE_DEPTH = 3;
  localparam int BR_PEN     = 1;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wreg;
  logic [4:0]       id_dest;
  logic             id_branch;
  logic             stat_clr;
  logic             cu_wpcir;
  logic             id_bubble;
  logic             hz_data;
  logic             hz_ctrl;
  logic [CNT_W-1:0] stall_cnt;

  id_hazard_ctrl #(.PIPE_DEPTH(PIPE_DEPTH), .BR_PENALTY(BR_PEN), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_dest(id_dest),
    .id_branch(id_branch), .stat_clr(stat_clr), .cu_wpcir(cu_wpcir), .id_bubble(id_bubble),
    .hz_data(hz_data), .hz_ctrl(hz_ctrl), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state:
  //   wq   - destinations written by the last PIPE_DEPTH issue slots (0 = no write)
  //   pen  - branch penalty cycles still owed
  //   scnt - saturating stall count
  int wq[$];
  int pen  = 0;
  int scnt = 0;
  bit last_issue, obs_d, obs_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_data();
    if (!id_valid || pen != 0) return 1'b0;
    foreach (wq[i]) begin
      if (wq[i] != 0 && ((id_use_rs && int'(id_rs) == wq[i]) ||
                         (id_use_rt && int'(id_rt) == wq[i]))) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    wq.delete();
    pen  = 0;
    scnt = 0;
  endtask

  // One clock cycle: check every output at the falling edge, then advance the model at the rising edge.
  task automatic tick();
    bit d, c, s, iss;
    @(negedge clk);
    d = m_data();
    c = (pen != 0);
    s = d | c;
    if (!rst) begin
      d = 0;
      c = 0;
      s = 0;
    end
    chk("hz_data",   32'(hz_data),   32'(d));
    chk("hz_ctrl",   32'(hz_ctrl),   32'(c));
    chk("cu_wpcir",  32'(cu_wpcir),  32'(s));
    chk("id_bubble", 32'(id_bubble), 32'(s));
    chk("stall_cnt", 32'(stall_cnt), 32'(scnt));
    obs_d = hz_data;
    obs_c = hz_ctrl;
    @(posedge clk);
    last_issue = 1'b0;
    if (rst) begin
      iss = id_valid && !s;
      last_issue = iss;
      wq.push_front((iss && id_wreg) ? int'(id_dest) : 0);
      if (wq.size() > PIPE_DEPTH) void'(wq.pop_back());
      if (pen > 0) pen--;
      else if (id_valid && id_branch && !d) pen = BR_PEN;
      if (stat_clr) scnt = 0;
      else if (s && scnt < CNT_MAX) scnt++;
    end
    #1;
  endtask

  task automatic set_instr(input bit v, input int rs, input int rt, input bit urs,
                           input bit urt, input bit wr, input int dst, input bit br);
    id_valid  = v;
    id_rs     = 5'(rs);
    id_rt     = 5'(rt);
    id_use_rs = urs;
    id_use_rt = urt;
    id_wreg   = wr;
    id_dest   = 5'(dst);
    id_branch = br;
  endtask

  // Present an instruction and hold it until it issues.
  // nd/nc count the hazard cycles the DUT reports while the instruction is held.
  task automatic issue(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit wr, input int dst, input bit br, output int nd, output int nc);
    bit done;
    set_instr(v, rs, rt, urs, urt, wr, dst, br);
    nd = 0;
    nc = 0;
    done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      tick();
      nd += int'(obs_d);
      nc += int'(obs_c);
      if (last_issue || !v) done = 1;
    end
    if (!done) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic flush_clr();
    int a, b;
    stat_clr = 1'b1;
    for (int i = 0; i < PIPE_DEPTH; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, a, b);
    stat_clr = 1'b0;
  endtask

  initial begin
    int nd, nc, a, b;
    rst = 1'b0;
    stat_clr = 1'b0;
    last_issue = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    tick();
    tick();
    rst = 1'b1;

    // Back-to-back RAW dependency: 3 stall cycles.
    flush_clr();
    issue(1, 1, 2, 1, 1, 1, 3, 0, a, b);
    issue(1, 3, 5, 1, 1, 1, 4, 0, nd, nc);
    chk("raw_k1_stalls", 32'(nd), 32'd3);
    chk("raw_k1_cnt", 32'(stall_cnt), 32'd3);

    // One to three independent instructions between writer and reader.
    for (int gap = 1; gap <= 3; gap++) begin
      flush_clr();
      issue(1, 1, 2, 1, 1, 1, 3, 0, a, b);
      for (int g = 0; g < gap; g++) issue(1, 1, 2, 1, 1, 1, 10, 0, a, b);
      issue(1, 5, 3, 1, 1, 1, 4, 0, nd, nc);
      chk("raw_gap_stalls", 32'(nd), 32'(3 - gap));
    end

    // Register 0 never hazards, and an unused rt does not hazard.
    flush_clr();
    issue(1, 1, 2, 1, 1, 1, 0, 0, a, b);
    issue(1, 0, 0, 1, 1, 1, 6, 0, nd, nc);
    chk("r0_no_stall", 32'(nd), 32'd0);
    issue(1, 1, 2, 1, 1, 1, 5, 0, a, b);
    issue(1, 1, 5, 1, 0, 1, 6, 0, nd, nc);
    chk("unused_rt_no_stall", 32'(nd), 32'd0);
    chk("r0_cnt_zero", 32'(stall_cnt), 32'd0);

    // A branch without a hazard, then a branch behind a write to r7.
    flush_clr();
    issue(1, 1, 2, 1, 1, 0, 0, 1, nd, nc);
    chk("br_free_data", 32'(nd), 32'd0);
    issue(1, 1, 2, 1, 1, 1, 9, 0, nd, nc);
    chk("br_free_ctrl", 32'(nc), 32'(BR_PEN));
    flush_clr();
    issue(1, 1, 2, 1, 1, 1, 7, 0, a, b);
    issue(1, 7, 0, 1, 0, 0, 0, 1, nd, nc);
    chk("br_raw_data", 32'(nd), 32'd3);
    issue(1, 1, 2, 1, 1, 1, 9, 0, nd, nc);
    chk("br_raw_ctrl", 32'(nc), 32'd1);
    chk("br_raw_cnt", 32'(stall_cnt), 32'd4);

    // Saturation of the stall counter, then a clear during a stall.
    flush_clr();
    for (int k = 0; k < 6; k++) begin
      issue(1, 1, 2, 1, 1, 1, 3, 0, a, b);
      issue(1, 3, 3, 1, 1, 1, 4, 0, a, b);
    end
    chk("cnt_saturated", 32'(stall_cnt), 32'(CNT_MAX));
    issue(1, 1, 2, 1, 1, 1, 3, 0, a, b);
    set_instr(1, 3, 2, 1, 1, 1, 4, 0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clr_zero", 32'(stall_cnt), 32'd0);
    issue(1, 3, 2, 1, 1, 1, 4, 0, nd, nc);

    // Reset asserted during BR_WAIT while the scoreboard holds r3.
    flush_clr();
    issue(1, 1, 2, 1, 1, 1, 3, 0, a, b);
    issue(1, 1, 2, 1, 1, 0, 0, 1, a, b);
    set_instr(1, 3, 2, 1, 1, 1, 4, 0);
    #2 rst = 1'b0;
    #1;
    chk("rst_wpcir", 32'(cu_wpcir), 32'd0);
    chk("rst_ctrl",  32'(hz_ctrl),  32'd0);
    chk("rst_data",  32'(hz_data),  32'd0);
    chk("rst_cnt",   32'(stall_cnt), 32'd0);
    model_reset();
    tick();
    rst = 1'b1;
    issue(1, 3, 2, 1, 1, 1, 4, 0, nd, nc);
    chk("post_rst_stalls", 32'(nd + nc), 32'd0);

    // Random instruction stream from a small register set, so hazards are frequent.
    for (int n = 0; n < 300; n++) begin
      stat_clr = ($urandom_range(0, 19) == 0);
      issue($urandom_range(0, 7) != 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
            $urandom_range(0, 7) == 0, a, b);
    end
    stat_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
